// File: rtl/zprize_mul_pkg.sv
// Shared types and helpers for the zprize multiplier credit buffer slice.
package zprize_mul_pkg;

  localparam int unsigned W_DEFAULT = 384;
  localparam int unsigned PW        = 2 * W_DEFAULT;

  typedef enum logic {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } mulbuf_state_t;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/zprize_sfifo_fwft.sv
// Synchronous first-word-fall-through FIFO; head is visible on rd_data while !empty.
module zprize_sfifo_fwft
  import zprize_mul_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PTRW = cnt_w(DEPTH);

  logic [DW-1:0]   mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic            do_wr;
  logic            do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot the write lands in, so full+pop still writes.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/zprize_mul_credit_buf.sv
// Credit-controlled issue/capture wrapper around the fixed-latency zprize_mul_96 multiplier.
// Optional statistics outputs enabled by defining ZPRIZE_MULBUF_STATS_EN.
module zprize_mul_credit_buf
  import zprize_mul_pkg::*;
#(
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned M     = 32,
  parameter int unsigned LAT   = 14,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     req_in0,
  input  logic [W-1:0]     req_in1,
  input  logic [M-1:0]     req_m,
  output logic [W-1:0]     mul_in0,
  output logic [W-1:0]     mul_in1,
  output logic [M:0]       mul_m_i,
  input  logic [2*W-1:0]   mul_out0,
  input  logic [M:0]       mul_m_o,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*W-1:0]   res_prod,
  output logic [M-1:0]     res_m,
  output logic             err_ovf
`ifdef ZPRIZE_MULBUF_STATS_EN
  ,
  output logic [cnt_w(DEPTH)-1:0] stat_inflight,
  output logic [31:0]             stat_issued,
  output logic [31:0]             stat_retired
`endif
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned FW = cnt_w(LAT);
  localparam int unsigned DW = M + 2 * W;

  mulbuf_state_t state, state_nxt;
  logic [FW-1:0] flush_cnt, flush_nxt;
  logic [CW-1:0] credits;
  logic          issue;
  logic          pop;
  logic          wr_en;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FLUSH;
      flush_cnt <= FW'(LAT);
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    flush_nxt = flush_cnt;
    case (state)
      FLUSH: begin
        if (flush_cnt == '0) state_nxt = RUN;
        else                 flush_nxt = flush_cnt - 1'b1;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = FLUSH;
    endcase
  end

  // rst also masks ready so nothing is issued in the cycle reset is applied.
  assign req_ready = (state == RUN) & (credits != '0) & ~rst;
  assign issue     = req_valid & req_ready;
  assign pop       = res_valid & res_ready;

  assign mul_in0 = req_in0;
  assign mul_in1 = req_in1;
  assign mul_m_i = {req_m, issue};

  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CW'(DEPTH);
    end else begin
      case ({issue, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // Products emerging during FLUSH are stale datapath contents and are never captured.
  assign wr_en = (state == RUN) & mul_m_o[0];

  zprize_sfifo_fwft #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data ({mul_m_o[M:1], mul_out0}),
    .full    (fifo_full),
    .rd_en   (res_ready),
    .rd_data (fifo_rd),
    .empty   (fifo_empty)
  );

  assign res_valid = ~fifo_empty;
  assign res_prod  = fifo_rd[2*W-1:0];
  assign res_m     = fifo_rd[DW-1 -: M];

  always_ff @(posedge clk) begin
    if (rst)                                err_ovf <= 1'b0;
    else if (wr_en & fifo_full & ~pop)      err_ovf <= 1'b1;
  end

`ifdef ZPRIZE_MULBUF_STATS_EN
  assign stat_inflight = CW'(DEPTH) - credits;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued  <= '0;
      stat_retired <= '0;
    end else begin
      if (issue && (stat_issued != '1))  stat_issued  <= stat_issued + 1'b1;
      if (pop && (stat_retired != '1))   stat_retired <= stat_retired + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_zprize_mul_credit_buf.sv
// Self-checking bench: fake fixed-latency multiplier plus a queue-based reference model.
`timescale 1ns/1ps
module tb_zprize_mul_credit_buf;

  localparam int unsigned W     = 384;
  localparam int unsigned M     = 32;
  localparam int unsigned LAT   = 14;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PWB   = 2 * W;

  typedef logic [PWB-1:0] w_t;

  typedef struct {
    logic [M-1:0] m;
    w_t           p;
    int           rdy;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [W-1:0]   req_in0;
  logic [W-1:0]   req_in1;
  logic [M-1:0]   req_m;
  logic [W-1:0]   mul_in0;
  logic [W-1:0]   mul_in1;
  logic [M:0]     mul_m_i;
  logic [PWB-1:0] mul_out0;
  logic [M:0]     mul_m_o;
  logic           res_valid;
  logic           res_ready;
  logic [PWB-1:0] res_prod;
  logic [M-1:0]   res_m;
  logic           err_ovf;
  logic           inj_v;

  always #5 clk = ~clk;

  zprize_mul_credit_buf #(
    .W     (W),
    .M     (M),
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in0   (req_in0),
    .req_in1   (req_in1),
    .req_m     (req_m),
    .mul_in0   (mul_in0),
    .mul_in1   (mul_in1),
    .mul_m_i   (mul_m_i),
    .mul_out0  (mul_out0),
    .mul_m_o   (mul_m_o),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_prod  (res_prod),
    .res_m     (res_m),
    .err_ovf   (err_ovf)
  );

  // Fake multiplier: exact LAT-cycle delay line with no reset.
  w_t         pipe_p [LAT];
  logic [M:0] pipe_m [LAT];

  always @(posedge clk) begin
    pipe_p[0] <= w_t'(mul_in0) * w_t'(mul_in1);
    pipe_m[0] <= mul_m_i;
    for (int i = 1; i < LAT; i++) begin
      pipe_p[i] <= pipe_p[i-1];
      pipe_m[i] <= pipe_m[i-1];
    end
  end

  assign mul_out0 = pipe_p[LAT-1];
  assign mul_m_o  = {pipe_m[LAT-1][M:1], pipe_m[LAT-1][0] | inj_v};

  // Reference model state
  exp_t q[$];
  int   cyc_no     = 0;
  int   since_rst  = 0;
  bit   ovf_exp    = 1'b0;
  int   total      = 0;
  int   bad        = 0;
  int   n_acc_dut  = 0;
  int   n_pop_dut  = 0;

  task automatic check(input string tag, input w_t obs, input w_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < int'(W / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic rand_req();
    req_in0 = rand_w();
    req_in1 = rand_w();
    req_m   = $urandom;
  endtask

  // One clock cycle: compare at the falling edge, update the model, advance past the rising edge.
  task automatic cyc();
    logic exp_rdy;
    logic exp_v;
    int   buffered;
    @(negedge clk);
    if (rst) begin
      check("rst_req_ready", w_t'(req_ready), w_t'(1'b0));
      check("rst_issue_bit", w_t'(mul_m_i[0]), w_t'(1'b0));
    end else begin
      exp_rdy  = (since_rst > int'(LAT)) && (q.size() < int'(DEPTH));
      exp_v    = (q.size() > 0) && (q[0].rdy <= cyc_no);
      buffered = 0;
      foreach (q[i]) if (q[i].rdy <= cyc_no) buffered++;
      check("req_ready", w_t'(req_ready), w_t'(exp_rdy));
      check("res_valid", w_t'(res_valid), w_t'(exp_v));
      check("err_ovf", w_t'(err_ovf), w_t'(ovf_exp));
      if (req_valid && req_ready) n_acc_dut++;
      if (res_valid && res_ready) n_pop_dut++;
      if (inj_v && since_rst > int'(LAT) && buffered == int'(DEPTH) && !(exp_v && res_ready))
        ovf_exp = 1'b1;
      if (exp_v && res_ready) begin
        check("res_prod", w_t'(res_prod), q[0].p);
        check("res_m", w_t'(res_m), w_t'(q[0].m));
        void'(q.pop_front());
      end
      if (req_valid && exp_rdy) begin
        check("issue_bit", w_t'(mul_m_i[0]), w_t'(1'b1));
        q.push_back('{m: req_m, p: w_t'(req_in0) * w_t'(req_in1), rdy: cyc_no + int'(LAT) + 1});
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      ovf_exp   = 1'b0;
      since_rst = 0;
    end else begin
      since_rst++;
    end
    cyc_no++;
  endtask

  task automatic do_reset(input int n);
    req_valid = 1'b0;
    res_ready = 1'b0;
    inj_v     = 1'b0;
    rst       = 1'b1;
    repeat (n) cyc();
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    int t0;
    rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0; inj_v = 1'b0;
    req_in0 = '0; req_in1 = '0; req_m = '0;
    do_reset(LAT + 6);

    // Reset values, then flush window with valid held and stale valids injected
    check("reset_res_valid", w_t'(res_valid), w_t'(1'b0));
    check("reset_err_ovf", w_t'(err_ovf), w_t'(1'b0));
    req_valid = 1'b1; inj_v = 1'b1;
    repeat (LAT + 1) cyc();
    inj_v = 1'b0; req_valid = 1'b0;
    cyc();
    check("flush_no_write", w_t'(res_valid), w_t'(1'b0));

    // Single issue 3*5
    n_pop_dut = 0;
    req_in0 = W'(3); req_in1 = W'(5); req_m = M'(32'hA5); req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
    repeat (LAT) cyc();
    check("single_prod", w_t'(res_prod), w_t'(15));
    check("single_m", w_t'(res_m), w_t'(32'hA5));
    res_ready = 1'b1;
    repeat (3) cyc();
    check("single_pops", w_t'(n_pop_dut), w_t'(1));

    // Back-to-back stream of 64
    n_acc_dut = 0; n_pop_dut = 0; guard = 0; t0 = cyc_no;
    res_ready = 1'b1;
    while (n_acc_dut < 64 && guard < 200) begin
      rand_req(); req_valid = 1'b1; cyc(); guard++;
    end
    check("stream_issue_cycles", w_t'(cyc_no - t0), w_t'(64));
    req_valid = 1'b0;
    repeat (LAT + 4) cyc();
    check("stream_acc", w_t'(n_acc_dut), w_t'(64));
    check("stream_pop", w_t'(n_pop_dut), w_t'(64));

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rand_req();
      req_valid = $urandom_range(0, 1) != 0;
      res_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    req_valid = 1'b0; res_ready = 1'b1;
    repeat (LAT + DEPTH + 4) cyc();

    // Reset with 5 buffered and 8 in flight
    res_ready = 1'b0;
    repeat (5) begin rand_req(); req_valid = 1'b1; cyc(); end
    req_valid = 1'b0;
    repeat (LAT + 1) cyc();
    repeat (8) begin rand_req(); req_valid = 1'b1; cyc(); end
    do_reset(1);
    check("rst_clears_valid", w_t'(res_valid), w_t'(1'b0));
    n_pop_dut = 0; res_ready = 1'b1;
    repeat (LAT + 8) cyc();
    check("rst_none_appear", w_t'(n_pop_dut), w_t'(0));

    // Fill under backpressure: exactly DEPTH accepted, one more after a single pop
    res_ready = 1'b0; n_acc_dut = 0;
    for (int i = 0; i < 100; i++) begin rand_req(); req_valid = 1'b1; cyc(); end
    check("fill_acc", w_t'(n_acc_dut), w_t'(DEPTH));
    res_ready = 1'b1; cyc(); res_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin rand_req(); req_valid = 1'b1; cyc(); end
    check("fill_acc_plus1", w_t'(n_acc_dut), w_t'(DEPTH + 1));
    check("fill_no_ovf", w_t'(err_ovf), w_t'(1'b0));
    req_valid = 1'b0;

    // Forced write into a full FIFO
    inj_v = 1'b1; cyc(); inj_v = 1'b0;
    repeat (4) cyc();
    check("ovf_set", w_t'(err_ovf), w_t'(1'b1));
    n_pop_dut = 0; res_ready = 1'b1;
    repeat (DEPTH + 4) cyc();
    check("ovf_drain_pops", w_t'(n_pop_dut), w_t'(DEPTH));
    check("ovf_sticky", w_t'(err_ovf), w_t'(1'b1));
    do_reset(1);
    cyc();
    check("ovf_cleared", w_t'(err_ovf), w_t'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zprize_mul_credit_buf.md
# zprize_mul_credit_buf

Credit-controlled result buffer for the fixed-latency, non-stallable 384×384 Karatsuba multiplier (`zprize_mul_96`). It sits between the operand issuer and the multiplier, and between the multiplier and the next consumer. It carries a valid bit and user metadata through the multiplier's `m_i`/`m_o` sideband, captures every product into a FIFO, and throttles issue with credits so the FIFO can never overflow under consumer backpressure. It also flushes stale in-flight products after reset, because the multiplier datapath has no reset.

## Interface
Parameters:
- `W`, 384: operand width. The product is `2*W` bits.
- `M`, 32: user metadata width. The multiplier sideband width is `M+1`.
- `LAT`, 14: exact cycles from `mul_in*` to `mul_out0`. Must be at least 1.
- `DEPTH`, 16: result FIFO entries. Must be at least 2 and a power of two.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: issuer has operands.
- `req_ready` out 1: block accepts operands this cycle.
- `req_in0`, `req_in1` in `W`: operands.
- `req_m` in `M`: user metadata.
- `mul_in0`, `mul_in1` out `W`: to multiplier.
- `mul_m_i` out `M+1`: to multiplier, `{req_m, issue}`.
- `mul_out0` in `2*W`: product from multiplier.
- `mul_m_o` in `M+1`: sideband from multiplier; bit 0 is the valid bit.
- `res_valid` out 1: FIFO head valid.
- `res_ready` in 1: consumer pops the head.
- `res_prod` out `2*W`: product at the FIFO head.
- `res_m` out `M`: metadata at the FIFO head.
- `err_ovf` out 1: sticky; a write was attempted while the FIFO was full.

## Operation
- State machine has two states, `FLUSH` and `RUN`. `rst` forces `FLUSH` with `flush_cnt = LAT`.
- In `FLUSH`:
  - `flush_cnt` decrements each cycle.
  - When `flush_cnt` reaches 0, the next state is `RUN`.
  - `mul_m_o[0]` is ignored.
  - `req_ready` is 0.
- Issue:
  - `issue = req_valid & req_ready`.
  - `req_ready = (state==RUN) & (credits != 0)`, combinational.
  - `mul_in0`, `mul_in1` and `mul_m_i[M:1]` pass `req_in0`, `req_in1` and `req_m` through combinationally.
  - `mul_m_i[0] = issue`.
- Credits:
  - Reset value is `DEPTH`, width `$clog2(DEPTH)+1`.
  - Decrement on `issue`; increment on pop (`res_valid & res_ready`).
  - If both happen in the same cycle, the count is unchanged.
  - The count never leaves the range 0..`DEPTH`.
- Capture:
  - In `RUN`, `mul_m_o[0]=1` writes `{mul_m_o[M:1], mul_out0}` to the FIFO.
  - Write while full: data is dropped and `err_ovf` is set. It clears only on `rst`.
  - Credits make this condition unreachable in correct use.
- FIFO:
  - First-word-fall-through; `res_prod`/`res_m` show the head whenever `res_valid=1`.
  - Simultaneous write and pop are legal at any occupancy, including full (pop frees the slot, write takes it) and empty (the written word appears next cycle).
  - Pointers wrap modulo `DEPTH`. Occupancy is tracked with an extra pointer bit.
- Reset mid-operation:
  - All in-flight and buffered results are discarded.
  - Credits return to `DEPTH`.
  - Results that emerge during `FLUSH` are never written.

## Timing
- Reset values: `req_ready=0`, `res_valid=0`, `err_ovf=0`, `mul_m_i[0]=0`. `res_prod` and `res_m` are don't-care while `res_valid=0`.
- After `rst` deasserts, `req_ready` can first be 1 on cycle `LAT+1`.
- An operand accepted at cycle t gives `res_valid=1` with that product at cycle `t+LAT+1`, if the FIFO was empty.
- Sustained throughput is 1 product per cycle when `res_ready` is held at 1.
- With `res_ready=0`, at most `DEPTH` issues are accepted before `req_ready` drops. `req_ready` rises the cycle after a pop.
- Results leave in issue order.

## Configuration
- `ZPRIZE_MULBUF_STATS_EN` defined: adds output `stat_inflight` (`$clog2(DEPTH)+1` bits, equal to `DEPTH-credits`). It also adds 32-bit saturating counters `stat_issued` and `stat_retired`. All three reset to 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

## Structure
- Package `zprize_mul_pkg`:
  - `localparam` product width `PW = 2*W`.
  - State typedef `mulbuf_state_t` {`FLUSH`, `RUN`}.
  - Function `cnt_w(n) = $clog2(n)+1`.
- Sub-module `zprize_sfifo_fwft`: synchronous FWFT FIFO with parameters `DW`, `DEPTH`, ports `wr_en/wr_data/full/rd_en/rd_data/empty`. Reusable elsewhere.
- The multiplier is instantiated by the parent, not inside this block.

## Test plan
- Reset, then `req_valid=1` held: `req_ready=0` for cycles 0..`LAT`, then 1. Fake multiplier drives `mul_m_o[0]=1` during `FLUSH` → no FIFO write, `res_valid` stays 0.
- Single issue with `req_in0=3`, `req_in1=5`, `req_m=0xA5`, fake multiplier of latency `LAT` → `res_valid` at t+`LAT`+1, `res_prod=15`, `res_m=0xA5`.
- `res_ready=0` and 100 issue attempts → exactly `DEPTH`=16 accepted. Then pulse `res_ready` once → exactly one more accepted. `err_ovf` stays 0.
- Back-to-back stream of 64 issues with `res_ready=1` → 64 results in order, no bubble after the first, credits return to 16.
- `rst` pulsed with 8 results in flight and 5 buffered → `res_valid=0` next cycle, credits=16, none of the 13 ever appear.
- Force `mul_m_o[0]=1` on a full FIFO → `err_ovf=1` and stays set until `rst`; FIFO contents are unchanged.
